// File: rtl/door_pkg.sv
// Shared types and constants for the door access controller.
//   state_e      : controller states
//   KEY_CLEAR    : keypad code for clear
//   KEY_ENTER    : keypad code for enter
//   NUM_USERS    : comparator user slots (one-hot cmp_sw width)
//   timer_width  : bits needed to hold a cycle count
package door_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_DENIED,
    ST_LOCKED
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  localparam int unsigned NUM_USERS = 10;

  // +1 so a power-of-two load value still fits in the counter
  function automatic int unsigned timer_width(input int unsigned max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/door_hold_timer.sv
// Loadable down-counter shared by the unlock, deny and lockout holds.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset
//   load_i     : load value_i this cycle
//   value_i    : cycle count to load
//   done_o     : registered, high while the count sits at 1
module door_hold_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  // Next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // done is precomputed so it is a flop output aligned with cnt_q == 1
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/door_access_controller.sv
// PIN entry sequencer: collects four digits, samples the comparator verdict,
// and drives unlock / deny / lockout with a shared hold timer.
//   clk, reset         : clock, synchronous active-high reset
//   key_valid/key_code : keypad strobe and code (0..9 digit, 10 clear, 11 enter)
//   cmp_success/cmp_sw : comparator overall match and per-user one-hot match
//   digit4..digit1     : entered digits, first-entered in digit4
//   digit_count        : digits entered so far
//   unlock, user_id    : door release and granted user (1..10, 0 = none)
//   deny, lockout      : failure indication and keypad lockout
//   fail_count         : consecutive failed attempts
module door_access_controller
  import door_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000,
  parameter int unsigned DENY_CYCLES    = 50_000_000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       cmp_success,
  input  logic [9:0] cmp_sw,
  output logic [3:0] digit4,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [2:0] digit_count,
  output logic       unlock,
  output logic [3:0] user_id,
  output logic       deny,
  output logic       lockout,
  output logic [2:0] fail_count
);

  localparam int unsigned MAX_A   = (UNLOCK_CYCLES > DENY_CYCLES) ? UNLOCK_CYCLES : DENY_CYCLES;
  localparam int unsigned MAX_CYC = (LOCKOUT_CYCLES > MAX_A) ? LOCKOUT_CYCLES : MAX_A;
  localparam int unsigned TW      = timer_width(MAX_CYC);

  state_e          state_q;
  logic            digit_key_c, clear_key_c, enter_key_c;
  logic            grant_c, fail_c, lock_c, load_c;
  logic [2:0]      fail_next_c;
  logic [3:0]      grant_user_c;
  logic [TW-1:0]   load_val_c;
  logic            timer_done;

  // Key decode, attempt outcome and timer load for the state being entered
  always_comb begin
    digit_key_c  = key_valid && (key_code < 4'd10);
    clear_key_c  = key_valid && (key_code == KEY_CLEAR);
    enter_key_c  = key_valid && (key_code == KEY_ENTER);
    fail_next_c  = fail_count + 3'd1;
    lock_c       = (fail_next_c == 3'(MAX_FAILS));
    grant_c      = (state_q == ST_CHECK) && cmp_success;
    fail_c       = ((state_q == ST_CHECK) && !cmp_success) ||
                   ((state_q == ST_ENTRY) && enter_key_c && (digit_count != 3'd4));
    load_c       = grant_c || fail_c;
    load_val_c   = grant_c ? TW'(UNLOCK_CYCLES) :
                   lock_c  ? TW'(LOCKOUT_CYCLES) : TW'(DENY_CYCLES);
    // Lowest set bit wins; an empty cmp_sw grants with user 0
    grant_user_c = 4'd0;
    for (int i = int'(NUM_USERS) - 1; i >= 0; i--) begin
      if (cmp_sw[4'(i)]) grant_user_c = 4'(i + 1);
    end
  end

  door_hold_timer #(.W(TW)) u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (load_c),
    .value_i (load_val_c),
    .done_o  (timer_done)
  );

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      digit4      <= 4'd0;
      digit3      <= 4'd0;
      digit2      <= 4'd0;
      digit1      <= 4'd0;
      digit_count <= 3'd0;
      unlock      <= 1'b0;
      user_id     <= 4'd0;
      deny        <= 1'b0;
      lockout     <= 1'b0;
      fail_count  <= 3'd0;
    end else begin
      // A finished or aborted attempt always discards the entered digits
      if (clear_key_c && state_q == ST_ENTRY || fail_c || grant_c) begin
        digit4      <= 4'd0;
        digit3      <= 4'd0;
        digit2      <= 4'd0;
        digit1      <= 4'd0;
        digit_count <= 3'd0;
      end else if (digit_key_c && digit_count != 3'd4 &&
                   (state_q == ST_IDLE || state_q == ST_ENTRY)) begin
        digit4      <= digit3;
        digit3      <= digit2;
        digit2      <= digit1;
        digit1      <= key_code;
        digit_count <= digit_count + 3'd1;
      end

      if (fail_c) begin
        fail_count <= fail_next_c;
        deny       <= 1'b1;
        lockout    <= lock_c;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (digit_key_c) state_q <= ST_ENTRY;
        end
        ST_ENTRY: begin
          if (clear_key_c) begin
            state_q <= ST_IDLE;
          end else if (enter_key_c) begin
            if (digit_count == 3'd4) state_q <= ST_CHECK;
            else                     state_q <= lock_c ? ST_LOCKED : ST_DENIED;
          end
        end
        ST_CHECK: begin
          if (cmp_success) begin
            unlock     <= 1'b1;
            user_id    <= grant_user_c;
            fail_count <= 3'd0;
            state_q    <= ST_UNLOCKED;
          end else begin
            state_q <= lock_c ? ST_LOCKED : ST_DENIED;
          end
        end
        ST_UNLOCKED: begin
          if (timer_done) begin
            unlock  <= 1'b0;
            user_id <= 4'd0;
            state_q <= ST_IDLE;
          end
        end
        ST_DENIED: begin
          if (timer_done) begin
            deny    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (timer_done) begin
            deny       <= 1'b0;
            lockout    <= 1'b0;
            fail_count <= 3'd0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
